// File: rtl/pacman_move_scheduler.sv
// pacman_move_scheduler
//   Paces pacman movement with a free-running step timer, queues the player's
//   requested direction from the keys, checks the target tile in map RAM for a
//   wall and issues one single-cycle enable (with direction) per legal step.
//   The queued direction wins when its target is open. Otherwise the current
//   direction is tried.
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   key_{up,down,left,right}_i direction keys, active-high level
//   pacman_x_i, pacman_y_i    current tile position
//   map_address_read_o        registered map RAM read address (y*MAP_W + x)
//   map_data_in_i             map RAM data, valid one cycle after the address
//   enable_o                  single-cycle move strobe
//   move_vertical_o/left_o/up_o  registered direction of the last issued move
//   busy_o                    high whenever the FSM is not idle
module pacman_move_scheduler #(
    parameter int unsigned MAP_W       = 21,
    parameter int unsigned MAP_H       = 21,
    parameter int unsigned STEP_CYCLES = 12500000,
    parameter logic [2:0]  WALL_CODE   = 3'd1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       key_up_i,
    input  logic       key_down_i,
    input  logic       key_left_i,
    input  logic       key_right_i,
    input  logic [7:0] pacman_x_i,
    input  logic [7:0] pacman_y_i,
    output logic [8:0] map_address_read_o,
    input  logic [2:0] map_data_in_i,
    output logic       enable_o,
    output logic       move_vertical_o,
    output logic       move_left_o,
    output logic       move_up_o,
    output logic       busy_o
);
    localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {D_NONE, D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_e;
    typedef enum logic [2:0] {S_IDLE, S_RD_P, S_CHK_P, S_RD_C, S_CHK_C, S_ISSUE} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    dir_e          pend_q, pend_d, cur_q, cur_d, req_q, req_d, key_dir;
    logic [7:0]    x_q, x_d, y_q, y_d;
    logic [8:0]    addr_q, addr_d;
    logic          vert_q, vert_d, left_q, left_d, up_q, up_d;
    logic          tick;

    // Neighbour tile address with wrap at the map edges, 9-bit truncated.
    function automatic logic [8:0] tgt(input dir_e d, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] tx, ty;
        tx = {1'b0, x};
        ty = {1'b0, y};
        case (d)
            D_UP:    ty = (y == 8'd0) ? 9'(MAP_H - 1) : ty - 9'd1;
            D_DOWN:  ty = (y == 8'(MAP_H - 1)) ? 9'd0 : ty + 9'd1;
            D_LEFT:  tx = (x == 8'd0) ? 9'(MAP_W - 1) : tx - 9'd1;
            D_RIGHT: tx = (x == 8'(MAP_W - 1)) ? 9'd0 : tx + 9'd1;
            default: ;
        endcase
        return ty * 9'(MAP_W) + tx;
    endfunction

    assign tick = (timer_q == TMAX);

    always_comb begin
        key_dir = D_NONE;
        if      (key_up_i)    key_dir = D_UP;
        else if (key_down_i)  key_dir = D_DOWN;
        else if (key_left_i)  key_dir = D_LEFT;
        else if (key_right_i) key_dir = D_RIGHT;
    end

    always_comb begin
        state_d = state_q;
        timer_d = tick ? '0 : timer_q + 1'b1;
        pend_d  = (key_dir != D_NONE) ? key_dir : pend_q;
        cur_d   = cur_q;
        req_d   = req_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        vert_d  = vert_q;
        left_d  = left_q;
        up_d    = up_q;
        case (state_q)
            S_IDLE: if (tick) begin
                // Snapshot position and request so later key/position changes
                // cannot disturb a check in flight.
                x_d   = pacman_x_i;
                y_d   = pacman_y_i;
                req_d = pend_q;
                if (pend_q != D_NONE) begin
                    addr_d  = tgt(pend_q, pacman_x_i, pacman_y_i);
                    state_d = S_RD_P;
                end else if (cur_q != D_NONE) begin
                    addr_d  = tgt(cur_q, pacman_x_i, pacman_y_i);
                    state_d = S_RD_C;
                end
            end
            S_RD_P: state_d = S_CHK_P;
            S_CHK_P: begin
                if (map_data_in_i != WALL_CODE) begin
                    cur_d   = req_q;
                    vert_d  = (req_q == D_UP) || (req_q == D_DOWN);
                    left_d  = (req_q == D_LEFT);
                    up_d    = (req_q == D_UP);
                    state_d = S_ISSUE;
                end else if (cur_q != D_NONE && cur_q != req_q) begin
                    addr_d  = tgt(cur_q, x_q, y_q);
                    state_d = S_RD_C;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_C: state_d = S_CHK_C;
            S_CHK_C: begin
                if (map_data_in_i != WALL_CODE) begin
                    vert_d  = (cur_q == D_UP) || (cur_q == D_DOWN);
                    left_d  = (cur_q == D_LEFT);
                    up_d    = (cur_q == D_UP);
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pend_q  <= D_NONE;
            cur_q   <= D_NONE;
            req_q   <= D_NONE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            vert_q  <= 1'b0;
            left_q  <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            req_q   <= req_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            vert_q  <= vert_d;
            left_q  <= left_d;
            up_q    <= up_d;
        end
    end

    assign map_address_read_o = addr_q;
    assign enable_o           = (state_q == S_ISSUE);
    assign busy_o             = (state_q != S_IDLE);
    assign move_vertical_o    = vert_q;
    assign move_left_o        = left_q;
    assign move_up_o          = up_q;
endmodule

// File: tb/tb_pacman_move_scheduler.sv
// Directed bench for pacman_move_scheduler with STEP_CYCLES=8 and a 21x21
// map model returning data one cycle after the address.
module tb_pacman_move_scheduler;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       ku = 0, kd = 0, kl = 0, kr = 0;
    logic [7:0] px = 8'd5, py = 8'd5;
    logic [8:0] addr;
    logic [2:0] mdata = 3'd0;
    logic       en, mv, ml, mu, busy;
    logic [2:0] mem [0:440];
    int         pass_cnt = 0, tot_cnt = 0;

    pacman_move_scheduler #(.MAP_W(21), .MAP_H(21), .STEP_CYCLES(8), .WALL_CODE(3'd1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .key_up_i(ku), .key_down_i(kd), .key_left_i(kl), .key_right_i(kr),
        .pacman_x_i(px), .pacman_y_i(py),
        .map_address_read_o(addr), .map_data_in_i(mdata),
        .enable_o(en), .move_vertical_o(mv), .move_left_o(ml), .move_up_o(mu),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mdata <= (addr < 9'd441) ? mem[addr] : 3'd0;

    // Waits (bounded) for busy to rise (cycle T+1 after the tick), then
    // watches six cycles: address at T+1 and T+3, enable latency relative to
    // T+1, enable count, busy at T+5, and direction outputs at the enable.
    task automatic run_step(output logic rose, output logic [8:0] a1, output logic [8:0] a3,
                            output int lat, output int n_en, output logic b4,
                            output logic v, output logic l, output logic u);
        rose = 0; a1 = '0; a3 = '0; lat = -1; n_en = 0; b4 = 1; v = 0; l = 0; u = 0;
        for (int k = 0; k < 20 && !rose; k++) begin
            @(negedge clk);
            if (busy) rose = 1;
        end
        if (!rose) return;
        a1 = addr;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 2) a3 = addr;
            if (i == 4) b4 = busy;
            if (en) begin
                n_en++;
                if (lat < 0) begin lat = i; v = mv; l = ml; u = mu; end
            end
        end
    endtask

    logic       rose, b4, v, l, u;
    logic [8:0] a1, a3;
    int         lat, n_en;

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        tot_cnt++; if ({en, busy, mv, ml, mu} !== 5'b0) $display("FAIL reset_outs got %b want 00000", {en, busy, mv, ml, mu}); else pass_cnt++;
        tot_cnt++; if (addr !== 9'd0) $display("FAIL reset_addr got %0d want 0", addr); else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tot_cnt++; if (en !== 1'b0 || busy !== 1'b0) $display("FAIL idle_no_key got en=%b busy=%b want 0 0", en, busy); else pass_cnt++;
        end
    endtask

    task automatic test_pending_right();
        int cnt;
        kr = 1; @(negedge clk); kr = 0;
        run_step(rose, a1, a3, lat, n_en, b4, v, l, u);
        tot_cnt++; if (rose !== 1'b1) $display("FAIL right_busy got %b want 1", rose); else pass_cnt++;
        tot_cnt++; if (a1 !== 9'd111) $display("FAIL right_addr got %0d want 111", a1); else pass_cnt++;
        tot_cnt++; if (lat !== 2) $display("FAIL right_lat got %0d want 2", lat); else pass_cnt++;
        tot_cnt++; if ({v, l} !== 2'b00) $display("FAIL right_dir got v=%b l=%b want 0 0", v, l); else pass_cnt++;
        // Released key stays queued: pending path keeps issuing right every tick.
        for (int s = 0; s < 2; s++) begin
            run_step(rose, a1, a3, lat, n_en, b4, v, l, u);
            tot_cnt++; if (lat !== 2 || n_en !== 1 || {v, l} !== 2'b00) $display("FAIL right_repeat lat=%0d n=%0d v=%b l=%b want 2 1 0 0", lat, n_en, v, l); else pass_cnt++;
        end
        cnt = 0;
        for (int i = 0; i < 24; i++) begin @(negedge clk); if (en) cnt++; end
        tot_cnt++; if (cnt !== 3) $display("FAIL one_per_tick got %0d want 3", cnt); else pass_cnt++;
    endtask

    task automatic test_fallback();
        mem[89] = 3'd1;   // (5,4) is a wall
        ku = 1;
        for (int s = 0; s < 2; s++) begin
            run_step(rose, a1, a3, lat, n_en, b4, v, l, u);
            tot_cnt++; if (a1 !== 9'd89) $display("FAIL fb_addr_p got %0d want 89", a1); else pass_cnt++;
            tot_cnt++; if (a3 !== 9'd111) $display("FAIL fb_addr_c got %0d want 111", a3); else pass_cnt++;
            tot_cnt++; if (lat !== 4 || n_en !== 1) $display("FAIL fb_lat got %0d n=%0d want 4 1", lat, n_en); else pass_cnt++;
            tot_cnt++; if ({v, l} !== 2'b00) $display("FAIL fb_dir got v=%b l=%b want 0 0", v, l); else pass_cnt++;
        end
        ku = 0;
        mem[89] = 3'd0;
    endtask

    task automatic test_wrap_left();
        px = 8'd0; py = 8'd3; kl = 1;
        run_step(rose, a1, a3, lat, n_en, b4, v, l, u);
        kl = 0;
        tot_cnt++; if (a1 !== 9'd83) $display("FAIL wrap_addr got %0d want 83", a1); else pass_cnt++;
        tot_cnt++; if (lat !== 2) $display("FAIL wrap_lat got %0d want 2", lat); else pass_cnt++;
        tot_cnt++; if ({v, l} !== 2'b01) $display("FAIL wrap_dir got v=%b l=%b want 0 1", v, l); else pass_cnt++;
    endtask

    task automatic test_priority();
        px = 8'd5; py = 8'd5; ku = 1; kl = 1;
        run_step(rose, a1, a3, lat, n_en, b4, v, l, u);
        ku = 0; kl = 0;
        tot_cnt++; if (a1 !== 9'd89) $display("FAIL prio_addr got %0d want 89", a1); else pass_cnt++;
        tot_cnt++; if (lat !== 2 || {v, u} !== 2'b11) $display("FAIL prio_dir lat=%0d v=%b u=%b want 2 1 1", lat, v, u); else pass_cnt++;
    endtask

    task automatic test_both_walls();
        // cur is UP (89), request DOWN (131); both walls.
        mem[89] = 3'd1; mem[131] = 3'd1; kd = 1;
        for (int s = 0; s < 2; s++) begin
            run_step(rose, a1, a3, lat, n_en, b4, v, l, u);
            kd = 0;
            tot_cnt++; if (rose !== 1'b1 || a1 !== 9'd131 || a3 !== 9'd89) $display("FAIL walls_addr rose=%b a1=%0d a3=%0d want 1 131 89", rose, a1, a3); else pass_cnt++;
            tot_cnt++; if (n_en !== 0) $display("FAIL walls_no_en got %0d want 0", n_en); else pass_cnt++;
            tot_cnt++; if (b4 !== 1'b0) $display("FAIL walls_busy_drop got %b want 0", b4); else pass_cnt++;
        end
        mem[89] = 3'd0; mem[131] = 3'd0;
        run_step(rose, a1, a3, lat, n_en, b4, v, l, u);
        tot_cnt++; if (lat !== 2 || {v, u} !== 2'b10) $display("FAIL walls_retry lat=%0d v=%b u=%b want 2 1 0", lat, v, u); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        rose = 0;
        for (int k = 0; k < 20 && !rose; k++) begin @(negedge clk); if (busy) rose = 1; end
        tot_cnt++; if (rose !== 1'b1) $display("FAIL rst_mid_busy got %b want 1", rose); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        tot_cnt++; if ({en, busy, mv, ml, mu} !== 5'b0 || addr !== 9'd0) $display("FAIL rst_mid_outs got %b addr=%0d want 00000 0", {en, busy, mv, ml, mu}, addr); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (en || busy) seen = 1; end
        tot_cnt++; if (seen !== 1'b0) $display("FAIL rst_mid_quiet got %b want 0", seen); else pass_cnt++;
        kr = 1; @(negedge clk); kr = 0;
        run_step(rose, a1, a3, lat, n_en, b4, v, l, u);
        tot_cnt++; if (lat !== 2 || a1 !== 9'd111 || {v, l} !== 2'b00) $display("FAIL rst_mid_resume lat=%0d a1=%0d v=%b l=%b want 2 111 0 0", lat, a1, v, l); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 441; i++) mem[i] = 3'd0;
        test_reset();
        test_pending_right();
        test_fallback();
        test_wrap_left();
        test_priority();
        test_both_walls();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
